// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill controller:
// FSM state encoding and default geometry constants.
package icache_pkg;

    localparam int DATABITS      = 32;
    localparam int ADDRBITS      = 32;
    localparam int CACHEADDRBITS = 5;
    localparam int BANKNUM       = 4;
    localparam int TTLBITS       = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_FETCH  = 2'd2,
        ST_DONE   = 2'd3
    } icache_state_t;

endpackage

// File: rtl/icache_victim_sel.sv
// Victim selection: combinational argmax over the per-line TTL values.
// The line with the largest TTL wins; on equal TTLs the lowest index wins.
// The result is returned one-hot.
module icache_victim_sel #(
    parameter int BANKNUM = icache_pkg::BANKNUM,
    parameter int TTLBITS = icache_pkg::TTLBITS
) (
    input  logic [BANKNUM*TTLBITS-1:0] line_ttl,
    output logic [BANKNUM-1:0]         victim_onehot
);

    logic [TTLBITS-1:0] best_ttl_s;
    int                 best_idx_s;

    // Scan lines upward; strict greater-than keeps the earliest maximum.
    always_comb begin
        best_ttl_s = line_ttl[0 +: TTLBITS];
        best_idx_s = 0;
        for (int i = 1; i < BANKNUM; i++) begin
            if (line_ttl[i*TTLBITS +: TTLBITS] > best_ttl_s) begin
                best_ttl_s = line_ttl[i*TTLBITS +: TTLBITS];
                best_idx_s = i;
            end else begin
                best_ttl_s = best_ttl_s;
                best_idx_s = best_idx_s;
            end
        end
    end

    // Expand the winning index into a one-hot select.
    always_comb begin
        victim_onehot = '0;
        for (int i = 0; i < BANKNUM; i++) begin
            if (i == best_idx_s) begin
                victim_onehot[i] = 1'b1;
            end else begin
                victim_onehot[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/icache_flush_ctrl.sv
// Instruction-cache refill controller.
// On a global miss (request with every line missing) the controller latches
// the line-aligned section of the fetch address, picks the victim line with
// the highest TTL, then streams 2^CACHEADDRBITS words from memory into that
// line, one outstanding read at a time.
// Optional build macro ICACHE_FLUSH_STATS_EN adds a saturating 32-bit
// refill_count output that counts completed refills.
module icache_flush_ctrl #(
    parameter int DATABITS      = icache_pkg::DATABITS,
    parameter int ADDRBITS      = icache_pkg::ADDRBITS,
    parameter int CACHEADDRBITS = icache_pkg::CACHEADDRBITS,
    parameter int BANKNUM       = icache_pkg::BANKNUM,
    parameter int TTLBITS       = icache_pkg::TTLBITS
) (
    input  logic                       clk,
    input  logic                       reset_n,
    // core side
    input  logic [ADDRBITS-1:0]        icache_addr,
    input  logic                       icache_rdreq,
    output logic                       icache_busy,
    // line side
    input  logic [BANKNUM-1:0]         line_miss,
    input  logic [BANKNUM*TTLBITS-1:0] line_ttl,
    output logic [BANKNUM-1:0]         flush_mode,
    output logic                       flush_we,
    output logic [ADDRBITS-1:0]        flush_addr,
    output logic [DATABITS-1:0]        flush_in,
    // memory side
    output logic [ADDRBITS-1:0]        mem_addr,
    output logic                       mem_rdreq,
    input  logic [DATABITS-1:0]        mem_in,
    input  logic                       mem_in_valid
`ifdef ICACHE_FLUSH_STATS_EN
    ,
    output logic [31:0]                refill_count
`endif
);

    import icache_pkg::*;

    // Byte-offset bits inside one line (word index plus byte-in-word).
    localparam int                      OFFSET_BITS = CACHEADDRBITS + 2;
    localparam logic [ADDRBITS-1:0]     OFFSET_MASK = ADDRBITS'((64'd1 << OFFSET_BITS) - 64'd1);
    localparam logic [CACHEADDRBITS-1:0] CNT_ONE    = CACHEADDRBITS'(1);
    localparam logic [CACHEADDRBITS-1:0] CNT_LAST   = '1;

    icache_state_t            state_r;
    logic [CACHEADDRBITS-1:0] counter_r;
    logic [ADDRBITS-1:0]      section_r;
    logic [BANKNUM-1:0]       flush_mode_r;
    logic                     mem_rdreq_r;
    logic [ADDRBITS-1:0]      mem_addr_r;

    logic                     global_miss_s;
    logic [ADDRBITS-1:0]      section_s;
    logic [BANKNUM-1:0]       victim_s;
    logic                     word_done_s;

    // Address of word idx inside the line that starts at sec.
    function automatic logic [ADDRBITS-1:0] word_addr(
        input logic [ADDRBITS-1:0]      sec,
        input logic [CACHEADDRBITS-1:0] idx
    );
        word_addr = sec | (ADDRBITS'(idx) << 2);
    endfunction

    assign global_miss_s = icache_rdreq & (&line_miss);
    assign section_s     = icache_addr & ~OFFSET_MASK;
    assign word_done_s   = (state_r == ST_FETCH) & mem_in_valid;

    icache_victim_sel #(
        .BANKNUM (BANKNUM),
        .TTLBITS (TTLBITS)
    ) u_victim_sel (
        .line_ttl      (line_ttl),
        .victim_onehot (victim_s)
    );

    // Refill sequencer: state, word counter, latched section and the
    // registered line/memory control outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            counter_r    <= '0;
            section_r    <= '0;
            flush_mode_r <= '0;
            mem_rdreq_r  <= 1'b0;
            mem_addr_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (global_miss_s) begin
                        section_r <= section_s;
                        state_r   <= ST_SELECT;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_SELECT: begin
                    // Victim is captured here and held for the whole refill.
                    flush_mode_r <= victim_s;
                    counter_r    <= '0;
                    mem_rdreq_r  <= 1'b1;
                    mem_addr_r   <= section_r;
                    state_r      <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (mem_in_valid) begin
                        counter_r <= counter_r + CNT_ONE;
                        if (counter_r == CNT_LAST) begin
                            // Last word written: stop requesting, release the line.
                            flush_mode_r <= '0;
                            mem_rdreq_r  <= 1'b0;
                            mem_addr_r   <= '0;
                            state_r      <= ST_DONE;
                        end else begin
                            mem_addr_r   <= word_addr(section_r, counter_r + CNT_ONE);
                            state_r      <= ST_FETCH;
                        end
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    // One quiet cycle so the line can refresh its miss flag.
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    counter_r    <= '0;
                    flush_mode_r <= '0;
                    mem_rdreq_r  <= 1'b0;
                    mem_addr_r   <= '0;
                end
            endcase
        end
    end

    // Word write path: forward returning memory data to the line the same cycle.
    always_comb begin
        flush_we   = 1'b0;
        flush_in   = '0;
        flush_addr = '0;
        if (word_done_s) begin
            flush_we   = 1'b1;
            flush_in   = mem_in;
            flush_addr = mem_addr_r;
        end else begin
            flush_we   = 1'b0;
            flush_in   = '0;
            flush_addr = '0;
        end
    end

    // Core stall: busy through the refill, and already in the detecting cycle.
    always_comb begin
        icache_busy = 1'b0;
        if (state_r != ST_IDLE) begin
            icache_busy = 1'b1;
        end else begin
            icache_busy = global_miss_s & reset_n;
        end
    end

    assign flush_mode = flush_mode_r;
    assign mem_rdreq  = mem_rdreq_r;
    assign mem_addr   = mem_addr_r;

`ifdef ICACHE_FLUSH_STATS_EN
    logic done_entry_s;
    assign done_entry_s = word_done_s & (counter_r == CNT_LAST);

    // Completed-refill counter, saturating at all ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refill_count <= 32'd0;
        end else if (done_entry_s && (refill_count != 32'hFFFF_FFFF)) begin
            refill_count <= refill_count + 32'd1;
        end else begin
            refill_count <= refill_count;
        end
    end
`else
    // Statistics counter not built.
`endif

endmodule

// File: tb/tb_icache_flush_ctrl.sv
// Directed self-checking bench for icache_flush_ctrl (BANKNUM=4, 32-word lines).
module tb_icache_flush_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] icache_addr;
    logic        icache_rdreq;
    logic        icache_busy;
    logic [3:0]  line_miss;
    logic [31:0] line_ttl;
    logic [3:0]  flush_mode;
    logic        flush_we;
    logic [31:0] flush_addr;
    logic [31:0] flush_in;
    logic [31:0] mem_addr;
    logic        mem_rdreq;
    logic [31:0] mem_in;
    logic        mem_in_valid;
`ifdef ICACHE_FLUSH_STATS_EN
    logic [31:0] refill_count;
`endif

    int errors = 0;
    int checks = 0;
    int we_count;

    icache_flush_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .icache_addr  (icache_addr),
        .icache_rdreq (icache_rdreq),
        .icache_busy  (icache_busy),
        .line_miss    (line_miss),
        .line_ttl     (line_ttl),
        .flush_mode   (flush_mode),
        .flush_we     (flush_we),
        .flush_addr   (flush_addr),
        .flush_in     (flush_in),
        .mem_addr     (mem_addr),
        .mem_rdreq    (mem_rdreq),
        .mem_in       (mem_in),
        .mem_in_valid (mem_in_valid)
`ifdef ICACHE_FLUSH_STATS_EN
        ,
        .refill_count (refill_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entry: DUT in IDLE with a global miss on the inputs. Walks SELECT and
    // FETCH, serving nwords words with `delay` idle cycles before each one.
    // For a full line it ends in DONE.
    task automatic refill(input int delay, input int nwords, input logic [3:0] exp_mode,
                          input logic [31:0] exp_sec, input logic [7:0] tag);
        logic [31:0] orig_addr;
        logic [31:0] exp_addr;
        logic [31:0] data;
        orig_addr = icache_addr;
        #1;
        chk("busy_on_miss", 32'(icache_busy), 32'd1);
        chk("idle_mode", 32'(flush_mode), 32'd0);
        step();
        // SELECT: scramble the core address; the latched section must not move
        icache_addr = ~orig_addr;
        #1;
        chk("select_mode", 32'(flush_mode), 32'd0);
        chk("select_rdreq", 32'(mem_rdreq), 32'd0);
        chk("select_busy", 32'(icache_busy), 32'd1);
        step();
        we_count = 0;
        for (int w = 0; w < nwords; w++) begin
            exp_addr = exp_sec + 32'(w * 4);
            for (int d = 0; d < delay; d++) begin
                #1;
                chk("wait_rdreq", 32'(mem_rdreq), 32'd1);
                chk("wait_addr", mem_addr, exp_addr);
                chk("wait_no_we", 32'(flush_we), 32'd0);
                step();
            end
            data = {tag, 8'h5A, 8'h3C, 8'(w)};
            mem_in_valid = 1'b1;
            mem_in = data;
            #1;
            chk("fetch_mode", 32'(flush_mode), 32'(exp_mode));
            chk("fetch_rdreq", 32'(mem_rdreq), 32'd1);
            chk("fetch_addr", mem_addr, exp_addr);
            chk("fetch_we", 32'(flush_we), 32'd1);
            chk("fetch_faddr", flush_addr, exp_addr);
            chk("fetch_fin", flush_in, data);
            if (flush_we === 1'b1) we_count++;
            step();
            mem_in_valid = 1'b0;
            mem_in = 32'd0;
        end
        if (nwords == 32) begin
            #1;
            chk("done_mode", 32'(flush_mode), 32'd0);
            chk("done_rdreq", 32'(mem_rdreq), 32'd0);
            chk("done_busy", 32'(icache_busy), 32'd1);
            chk("done_we", 32'(flush_we), 32'd0);
            chk("we_pulses", 32'(we_count), 32'd32);
        end
        icache_addr = orig_addr;
    endtask

    initial begin
        reset_n      = 1'b0;
        icache_addr  = 32'd0;
        icache_rdreq = 1'b0;
        line_miss    = 4'd0;
        line_ttl     = 32'd0;
        mem_in       = 32'd0;
        mem_in_valid = 1'b0;
        #2;
        // reset state
        chk("rst_busy", 32'(icache_busy), 32'd0);
        chk("rst_mode", 32'(flush_mode), 32'd0);
        chk("rst_we", 32'(flush_we), 32'd0);
        chk("rst_rdreq", 32'(mem_rdreq), 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_faddr", flush_addr, 32'd0);
        chk("rst_fin", flush_in, 32'd0);
`ifdef ICACHE_FLUSH_STATS_EN
        chk("rst_count", refill_count, 32'd0);
`endif
        step();
        step();
        reset_n = 1'b1;
        step();

        // TTLs {3,9,9,1}: line 1 wins the tie with line 2
        line_ttl     = {8'd1, 8'd9, 8'd9, 8'd3};
        line_miss    = 4'hF;
        icache_addr  = 32'h0000_1234;
        icache_rdreq = 1'b1;
        refill(0, 32, 4'b0010, 32'h0000_1200, 8'h01);
        line_miss = 4'b1101;
        #1;
        chk("done_busy_hit", 32'(icache_busy), 32'd1);
        step();
        #1;
        chk("idle_busy", 32'(icache_busy), 32'd0);
        chk("idle_rdreq", 32'(mem_rdreq), 32'd0);
        icache_rdreq = 1'b0;
`ifdef ICACHE_FLUSH_STATS_EN
        chk("count_1", refill_count, 32'd1);
`endif

        // All TTLs zero -> line 0; every word delayed 5 cycles
        line_ttl     = 32'd0;
        line_miss    = 4'hF;
        icache_addr  = 32'hDEAD_BEEF;
        icache_rdreq = 1'b1;
        refill(5, 32, 4'b0001, 32'hDEAD_BE80, 8'h02);
        line_miss = 4'b0000;
        step();
        #1;
        chk("idle_busy2", 32'(icache_busy), 32'd0);
`ifdef ICACHE_FLUSH_STATS_EN
        chk("count_2", refill_count, 32'd2);
`endif

        // Partial miss: no refill, stray mem_in_valid ignored
        line_miss    = 4'b1011;
        icache_addr  = 32'h0000_1234;
        icache_rdreq = 1'b1;
        #1;
        chk("partial_busy", 32'(icache_busy), 32'd0);
        mem_in_valid = 1'b1;
        mem_in       = 32'hCAFE_F00D;
        #1;
        chk("stray_we", 32'(flush_we), 32'd0);
        chk("stray_fin", flush_in, 32'd0);
        step();
        #1;
        chk("partial_rdreq", 32'(mem_rdreq), 32'd0);
        chk("partial_mode", 32'(flush_mode), 32'd0);
        chk("partial_busy2", 32'(icache_busy), 32'd0);
        mem_in_valid = 1'b0;
        mem_in       = 32'd0;
        step();

        // Reset at word 10 of a refill into line 3
        line_ttl    = {8'd200, 8'd5, 8'd7, 8'd1};
        line_miss   = 4'hF;
        icache_addr = 32'h0004_0040;
        refill(0, 10, 4'b1000, 32'h0004_0000, 8'h03);
        #1;
        chk("w10_rdreq", 32'(mem_rdreq), 32'd1);
        chk("w10_addr", mem_addr, 32'h0004_0028);
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(icache_busy), 32'd0);
        chk("arst_mode", 32'(flush_mode), 32'd0);
        chk("arst_rdreq", 32'(mem_rdreq), 32'd0);
        chk("arst_maddr", mem_addr, 32'd0);
        chk("arst_we", 32'(flush_we), 32'd0);
`ifdef ICACHE_FLUSH_STATS_EN
        chk("arst_count", refill_count, 32'd0);
`endif
        icache_rdreq = 1'b0;
        line_miss    = 4'd0;
        step();
        reset_n = 1'b1;
        step();
        mem_in_valid = 1'b1;
        mem_in       = 32'h1111_2222;
        #1;
        chk("late_valid_we", 32'(flush_we), 32'd0);
        chk("late_valid_fin", flush_in, 32'd0);
        step();
        mem_in_valid = 1'b0;
        mem_in       = 32'd0;
        #1;
        chk("post_rst_mode", 32'(flush_mode), 32'd0);
        chk("post_rst_busy", 32'(icache_busy), 32'd0);

`ifdef ICACHE_FLUSH_STATS_EN
        // Three back-to-back refills with the miss held throughout
        line_ttl     = {8'd2, 8'd4, 8'd6, 8'd8};
        line_miss    = 4'hF;
        icache_addr  = 32'h0000_0100;
        icache_rdreq = 1'b1;
        for (int r = 0; r < 3; r++) begin
            refill(0, 32, 4'b0001, 32'h0000_0100, 8'(8'h10 + r));
            step();
        end
        #1;
        chk("count_3", refill_count, 32'd3);
        icache_rdreq = 1'b0;
        line_miss    = 4'd0;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_flush_ctrl.md
ICACHE_FLUSH_CTRL -- requirements
Module: icache_flush_ctrl

Interface
REQ-001 Parameters SHALL be:
- DATABITS=32: word width.
- ADDRBITS=32: byte address width.
- CACHEADDRBITS=5: log2 words per line.
- BANKNUM=4: number of cache lines.
- TTLBITS=8: TTL width.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
REQ-003 Core-side ports SHALL be:
- icache_addr  in  ADDRBITS  core fetch byte address.
- icache_rdreq  in  1  core fetch request.
- icache_busy  out  1  refill in progress or miss pending; core holds its request.
REQ-004 Line-side ports SHALL be:
- line_miss  in  BANKNUM  per-line miss flags, bit i = line i.
- line_ttl  in  BANKNUM*TTLBITS  packed TTLs, line i at [i*TTLBITS +: TTLBITS].
- flush_mode  out  BANKNUM  one-hot refill select.
- flush_we  out  1  word write strobe.
- flush_addr  out  ADDRBITS  word byte address.
- flush_in  out  DATABITS  refill data.
REQ-005 Memory-side ports SHALL be:
- mem_addr  out  ADDRBITS  word read address.
- mem_rdreq  out  1  read request.
- mem_in  in  DATABITS  read data.
- mem_in_valid  in  1  read data valid.

Function
REQ-006 The FSM SHALL have states IDLE, SELECT, FETCH, DONE.
REQ-007 A global miss SHALL be icache_rdreq=1 with all line_miss bits =1; in IDLE a global miss SHALL latch the section {icache_addr[ADDRBITS-1:CACHEADDRBITS+2], zeros} and move to SELECT.
REQ-008 SELECT SHALL last one cycle and register the victim as the line with the maximum line_ttl, lowest index winning ties; the FSM then moves to FETCH.
REQ-009 In FETCH, flush_mode SHALL be one-hot on the victim; all other states drive flush_mode = 0.
REQ-010 A word counter of CACHEADDRBITS bits SHALL start at 0 on entry to FETCH.
- mem_addr = section | (counter<<2).
- mem_rdreq =1, held with mem_addr stable until mem_in_valid.
- At most one read outstanding.
REQ-011 The cycle mem_in_valid=1 in FETCH SHALL combinationally drive:
- flush_we=1, flush_in=mem_in, flush_addr=mem_addr.
- counter increments at the following clock edge.
REQ-012 mem_in_valid outside FETCH SHALL be ignored.
REQ-013 When the word at counter = 2^CACHEADDRBITS-1 is written, the FSM SHALL move to DONE; the counter wraps, with no extra request issued.
REQ-014 DONE SHALL last one cycle with flush_mode=0 so the line re-evaluates its miss flag; the FSM then returns to IDLE.
- A global miss present in DONE is not acted on; the FSM re-detects it in IDLE on the next cycle.
REQ-015 icache_busy SHALL be =1 when state != IDLE, or when in IDLE with a global miss present.
REQ-016 A change of icache_addr during SELECT, FETCH or DONE SHALL not affect the latched section.

Reset
REQ-017 Asserting reset_n=0 SHALL, asynchronously:
- set state=IDLE and counter=0.
- set flush_mode=0, flush_we=0, mem_rdreq=0, icache_busy=0.
- set mem_addr=0, flush_addr=0, flush_in=0.
REQ-018 Reset asserted mid-FETCH SHALL abandon the refill; a subsequently returning mem_in_valid SHALL be ignored.

Configuration
REQ-019 Macro ICACHE_FLUSH_STATS_EN SHALL control the refill-statistics output.
- Defined: add output refill_count, 32 bits, reset 0, +1 on each DONE entry, saturating at 32'hFFFFFFFF.
- Undefined: the port and its counter SHALL be absent.

Structure
REQ-020 A shared package icache_pkg SHALL hold:
- the FSM state enum.
- the default parameter constants DATABITS, ADDRBITS, CACHEADDRBITS, BANKNUM, TTLBITS.
REQ-021 Victim selection SHALL be a sub-module icache_victim_sel: combinational max-TTL argmax over BANKNUM inputs, lowest-index tie-break, one-hot output.

Verification
REQ-022 The bench SHALL cover these directed scenarios (BANKNUM=4, CACHEADDRBITS=5):
- TTLs {3,9,9,1}, rdreq at addr 0x0000_1234 with all misses -> victim one-hot 4'b0010; 32 reads 0x0000_1200..0x0000_127C; 32 flush_we pulses; DONE; IDLE.
- mem_in_valid delayed 5 cycles per word -> mem_rdreq and mem_addr held stable 5 cycles; exactly one flush_we per word; total 32.
- line_miss=4'b1011 with rdreq -> no refill; icache_busy=0.
- reset_n pulsed low at word 10 of FETCH -> all outputs 0 immediately; a later mem_in_valid yields no flush_we.
- All TTLs 0 -> victim line 0 (4'b0001).
- With ICACHE_FLUSH_STATS_EN, three back-to-back refills -> refill_count=3.
